// File: rtl/uart_tx_dev_io.sv
// ---------------------------------------------------------------------------
// UartTxDevIo (module uart_tx_dev_io)
//
// A UART transmitter that sits on the bus as a responder. The CPU writes
// bytes into a small TX FIFO. An FSM then sends each byte on txd as a UART
// frame. A status word is offered back for read muxing.
//
// Ports:
//   clk            peripheral clock, rising edge
//   rst            asynchronous reset, active-high
//   uart_we        one-cycle write strobe from the bus
//   uart_addr      0 = DATA register (push byte), 1 = CTRL register
//   Peripheral_in  CPU write data (DATA uses [7:0], CTRL uses [2:0])
//   uart_out       status: [0]=full [1]=empty [2]=busy [3]=irq_en
//                  [4]=overflow [5]=odd parity select [15:8]=fill count
//   txd            serial output, idle high, registered
//   busy           high whenever the FSM is not in IDLE, registered
//   irq            level interrupt: irq_en & FIFO empty & FSM idle, registered
//
// Optional feature macro: UART_TX_PARITY_EN
//   If defined: a PARITY bit follows the data bits (8E1 by default).
//   CTRL bit2 selects odd parity.
//   If undefined: the frame is plain 8N1 and CTRL bit2 is ignored.
// ---------------------------------------------------------------------------
module uart_tx_dev_io #(
    parameter int DIVISOR    = 434,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_we,
    input  logic        uart_addr,
    input  logic [31:0] Peripheral_in,
    output logic [31:0] uart_out,
    output logic        txd,
    output logic        busy,
    output logic        irq
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int TMR_W = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(DIVISOR - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } txState_t;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd4
    } txState_t;
`endif

    // FIFO storage and bookkeeping
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wrPtr_q, rdPtr_q;
    logic [CNT_W-1:0] count_q, count_d;

    // CTRL / status registers
    logic overflow_q, overflow_d;
    logic irqEn_q, irqEn_d;
    logic oddBit;

    // Transmit FSM state
    txState_t         state_q;
    logic [TMR_W-1:0] timer_q;
    logic [2:0]       bitIdx_q;
    logic [7:0]       shift_q;
    logic             txd_q, busy_q, irq_q;
    logic             parBit_q;

    // Bus decode and FIFO handshake signals
    logic dataWr, ctrlWr, full, empty, push, pop, timerWrap, idleIrq;
    logic unusedBits;

    assign dataWr    = uart_we & ~uart_addr;
    assign ctrlWr    = uart_we & uart_addr;
    assign full      = (count_q == DEPTH_C);
    assign empty     = (count_q == '0);
    // The full check uses the count from before this edge. So a pop in the
    // same cycle does not make room for the push.
    assign push      = dataWr & ~full;
    assign pop       = (state_q == IDLE) & ~empty;
    assign timerWrap = (timer_q == TMR_LAST);
    // irq is re-evaluated on the values that will exist after this edge.
    // This keeps the registered irq in step with the state it describes.
    assign idleIrq   = irqEn_d & (count_d == '0);
    assign unusedBits = ^Peripheral_in[31:8];

    // Next-state values for the fill count and the CTRL bits.
    // A set of overflow by a dropped write wins over a clear from CTRL.
    always_comb begin
        count_d    = count_q;
        overflow_d = overflow_q;
        irqEn_d    = irqEn_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push && pop) begin
            count_d = count_q - CNT_W'(1);
        end
        if (ctrlWr) begin
            irqEn_d = Peripheral_in[1];
            if (Peripheral_in[0]) begin
                overflow_d = 1'b0;
            end
        end
        if (dataWr && full) begin
            overflow_d = 1'b1;
        end
    end

    // FIFO payload storage.
    // It has no reset: the cleared pointers and count make any old contents
    // unreachable.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wrPtr_q] <= Peripheral_in[7:0];
        end
    end

    // FIFO pointers, fill count and the CTRL/status registers.
    // The pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            irqEn_q    <= 1'b0;
        end else begin
            if (push) begin
                wrPtr_q <= wrPtr_q + PTR_W'(1);
            end
            if (pop) begin
                rdPtr_q <= rdPtr_q + PTR_W'(1);
            end
            count_q    <= count_d;
            overflow_q <= overflow_d;
            irqEn_q    <= irqEn_d;
        end
    end

`ifdef UART_TX_PARITY_EN
    logic oddSel_q;

    // Parity sense select. It is latched into the frame's parity bit when
    // the byte is popped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oddSel_q <= 1'b0;
        end else if (ctrlWr) begin
            oddSel_q <= Peripheral_in[2];
        end
    end
    assign oddBit = oddSel_q;
`else
    assign oddBit = 1'b0;
`endif

    // Transmit FSM.
    // txd, busy and irq are registered together with each state change.
    // So txd already carries the value of the new state during that state's
    // first cycle. Each non-idle state lasts exactly DIVISOR cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            bitIdx_q <= 3'd0;
            shift_q  <= 8'd0;
            parBit_q <= 1'b0;
            txd_q    <= 1'b1;
            busy_q   <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    timer_q <= '0;
                    if (pop) begin
                        shift_q  <= mem_q[rdPtr_q];
`ifdef UART_TX_PARITY_EN
                        parBit_q <= (^mem_q[rdPtr_q]) ^ oddSel_q;
`else
                        parBit_q <= 1'b0;
`endif
                        state_q  <= START;
                        txd_q    <= 1'b0;
                        busy_q   <= 1'b1;
                        irq_q    <= 1'b0;
                    end else begin
                        txd_q  <= 1'b1;
                        busy_q <= 1'b0;
                        irq_q  <= idleIrq;
                    end
                end
                START: begin
                    if (timerWrap) begin
                        timer_q  <= '0;
                        bitIdx_q <= 3'd0;
                        state_q  <= DATA;
                        txd_q    <= shift_q[0];
                    end else begin
                        timer_q <= timer_q + TMR_W'(1);
                    end
                end
                DATA: begin
                    if (timerWrap) begin
                        timer_q <= '0;
                        if (bitIdx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state_q <= PARITY;
                            txd_q   <= parBit_q;
`else
                            state_q <= STOP;
                            txd_q   <= 1'b1;
`endif
                        end else begin
                            // The next bit is shift_q[1], because the
                            // register shifts on this same edge.
                            shift_q  <= shift_q >> 1;
                            bitIdx_q <= bitIdx_q + 3'd1;
                            txd_q    <= shift_q[1];
                        end
                    end else begin
                        timer_q <= timer_q + TMR_W'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (timerWrap) begin
                        timer_q <= '0;
                        state_q <= STOP;
                        txd_q   <= 1'b1;
                    end else begin
                        timer_q <= timer_q + TMR_W'(1);
                    end
                end
`endif
                STOP: begin
                    if (timerWrap) begin
                        timer_q <= '0;
                        state_q <= IDLE;
                        txd_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        irq_q   <= idleIrq;
                    end else begin
                        timer_q <= timer_q + TMR_W'(1);
                    end
                end
                default: begin
                    timer_q <= '0;
                    state_q <= IDLE;
                    txd_q   <= 1'b1;
                    busy_q  <= 1'b0;
                    irq_q   <= 1'b0;
                end
            endcase
        end
    end

    // Status word for the CPU read mux.
    assign uart_out = {16'b0, 8'(count_q), 2'b0, oddBit, overflow_q,
                       irqEn_q, busy_q, empty, full};
    assign txd  = txd_q;
    assign busy = busy_q;
    assign irq  = irq_q;

endmodule
